// File: rtl/rnn_pkg.sv
// Shared RNN front-end definitions: feature geometry, word type and the
// packer state encoding.
package rnn_pkg;

  localparam int FLOAT_W  = 32;
  localparam int NUM_FEAT = 42;
  localparam int NUM_GAIN = 22;
  localparam int IDX_W    = $clog2(NUM_FEAT);

  typedef logic [FLOAT_W-1:0]          float_t;
  typedef logic [NUM_FEAT*FLOAT_W-1:0] feature_t;

  typedef enum logic [1:0] {
    COLLECT,
    DROP,
    XFER
  } packer_state_t;

endpackage

// File: rtl/rnn_feature_packer_if.sv
// Word stream in and assembled feature frame out of the packer.
interface rnn_feature_packer_if;
  import rnn_pkg::*;

  float_t   s_data;
  logic     s_valid;
  logic     s_last;
  logic     s_ready;
  feature_t feature;
  logic     feat_valid;
  logic     feat_ready;

  modport master (
    output s_data, s_valid, s_last, feat_ready,
    input  s_ready, feature, feat_valid
  );

  modport slave (
    input  s_data, s_valid, s_last, feat_ready,
    output s_ready, feature, feat_valid
  );

endinterface

// File: rtl/rnn_feature_packer.sv
// Packs a serial stream of NUM_FEAT float words into one flat feature bus,
// rejecting frames whose s_last does not land on the final word.
module rnn_feature_packer
  import rnn_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rnn_feature_packer_if.slave  bus,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     frame_cnt
);

  packer_state_t state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic live;
  logic accept, at_end, slot_free, load, err_nxt;
  logic [NUM_FEAT-1:0][FLOAT_W-1:0] asm_buf;

  // live holds s_ready low until the first clock edge after reset release.
  assign bus.s_ready = live && (state != XFER);
  assign accept      = bus.s_valid && bus.s_ready;
  assign at_end      = (idx == IDX_W'(NUM_FEAT - 1));
  assign slot_free   = !bus.feat_valid || bus.feat_ready;

  // NOTE: every variable is given a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_nxt   = 1'b0;
    load      = 1'b0;
    case (state)
      COLLECT: begin
        if (accept) begin
          if (!at_end) begin
            if (bus.s_last) begin
              err_nxt = 1'b1;
              idx_nxt = '0;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            idx_nxt = '0;
            if (bus.s_last) begin
              state_nxt = XFER;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = DROP;
            end
          end
        end
      end
      DROP: begin
        if (accept && bus.s_last) state_nxt = COLLECT;
      end
      XFER: begin
        if (slot_free) begin
          load      = 1'b1;
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      idx       <= '0;
      live      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      live      <= 1'b1;
      frame_err <= err_nxt;
    end
  end

  // NOTE: the assembly buffer is deliberately not reset; its contents are
  // only ever read after a complete frame has overwritten every slot.
  always_ff @(posedge clk) begin
    if (state == COLLECT && accept) asm_buf[idx] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.feature    <= '0;
      bus.feat_valid <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      if (load) begin
        bus.feature    <= asm_buf;
        bus.feat_valid <= 1'b1;
        frame_cnt      <= frame_cnt + 1'b1;
      end else if (bus.feat_ready) begin
        bus.feat_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rnn_feature_packer.sv
// Self-checking bench for rnn_feature_packer: directed sequences, a frame
// table and a scoreboard of expected feature frames.
module tb_rnn_feature_packer;
  import rnn_pkg::*;

  localparam int CNT_W = 16;

  logic clk;
  logic rst_n;
  logic frame_err;
  logic [CNT_W-1:0] frame_cnt;

  rnn_feature_packer_if bus ();

  rnn_feature_packer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;
  bit err_prev = 1'b0;
  feature_t exp_q[$];

  typedef struct {
    logic [127:0] name;
    int           nwords;
    int           last_at;
    bit           gaps;
    logic [31:0]  base;
    int           exp_err;
    int           exp_frames;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_feat(input string name, input feature_t act, input feature_t exp);
    int bad;
    checks++;
    bad = -1;
    for (int i = 0; i < NUM_FEAT; i++)
      if (bad < 0 && act[i*FLOAT_W +: FLOAT_W] !== exp[i*FLOAT_W +: FLOAT_W]) bad = i;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s word=%0d actual=%08h expected=%08h", name, bad,
               act[bad*FLOAT_W +: FLOAT_W], exp[bad*FLOAT_W +: FLOAT_W]);
    end
  endtask

  function automatic feature_t build(input logic [31:0] base);
    feature_t f;
    for (int i = 0; i < NUM_FEAT; i++) f[i*FLOAT_W +: FLOAT_W] = base + 32'(i);
    return f;
  endfunction

  // Caller sits at a negedge; returns at the negedge after acceptance.
  task automatic send_word(input float_t d, input bit last);
    int n;
    n = 0;
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=s_ready_low expected=s_ready_high");
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input int nwords, input int last_at, input bit gaps,
                            input logic [31:0] base);
    for (int i = 0; i < nwords; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) @(negedge clk);
      send_word(base + 32'(i), i == last_at);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: samples just after the falling edge.
  initial begin
    feature_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.feat_valid && bus.feat_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=%08h expected=none", bus.feature[31:0]);
        end else begin
          e = exp_q.pop_front();
          check_feat("scoreboard_frame", bus.feature, e);
        end
      end
      if (frame_err) begin
        err_seen++;
        if (err_prev) check("frame_err_width", 64'd2, 64'd1);
      end
      err_prev = frame_err;
    end
  end

  initial begin
    vec_t vecs[5];
    int   err0;
    logic [CNT_W-1:0] cnt0;

    vecs[0] = '{"short",         10,  9, 1'b0, 32'h4100_0000, 1, 0};
    vecs[1] = '{"after_short",   42, 41, 1'b0, 32'h4110_0000, 0, 1};
    vecs[2] = '{"long",          47, 46, 1'b0, 32'h4120_0000, 1, 0};
    vecs[3] = '{"after_long",    42, 41, 1'b0, 32'h4130_0000, 0, 1};
    vecs[4] = '{"gappy",         42, 41, 1'b1, 32'h3F80_0000, 0, 1};

    rst_n = 1'b0;
    bus.s_data = '0;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.feat_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_feat_valid", 64'(bus.feat_valid), 64'd0);
    check("rst_feature", 64'(bus.feature[63:0]), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check("release_s_ready_before_edge", 64'(bus.s_ready), 64'd0);
    @(negedge clk);
    check("release_s_ready", 64'(bus.s_ready), 64'd1);

    // Frame 1, no consumer.
    exp_q.push_back(build(32'h3F80_0000));
    send_frame(NUM_FEAT, NUM_FEAT - 1, 1'b0, 32'h3F80_0000);
    check("n1_feat_valid", 64'(bus.feat_valid), 64'd0);
    check("n1_s_ready", 64'(bus.s_ready), 64'd0);
    @(negedge clk);
    check("f1_feat_valid", 64'(bus.feat_valid), 64'd1);
    check("f1_word0", 64'(bus.feature[31:0]), 64'h3F80_0000);
    check("f1_word41", 64'(bus.feature[1343:1312]), 64'h3F80_0029);
    check("f1_frame_cnt", 64'(frame_cnt), 64'd1);
    check("f1_s_ready", 64'(bus.s_ready), 64'd1);

    // Frame 2 parks in XFER behind the unconsumed frame 1.
    exp_q.push_back(build(32'h4000_0000));
    send_frame(NUM_FEAT, NUM_FEAT - 1, 1'b0, 32'h4000_0000);
    repeat (2) @(negedge clk);
    check("park_s_ready", 64'(bus.s_ready), 64'd0);
    check("park_feat_valid", 64'(bus.feat_valid), 64'd1);
    check("park_feature_held", 64'(bus.feature[31:0]), 64'h3F80_0000);
    check("park_frame_cnt", 64'(frame_cnt), 64'd1);
    bus.feat_ready = 1'b1;
    @(negedge clk);
    bus.feat_ready = 1'b0;
    check("reload_feat_valid", 64'(bus.feat_valid), 64'd1);
    check_feat("reload_feature", bus.feature, build(32'h4000_0000));
    check("reload_frame_cnt", 64'(frame_cnt), 64'd2);
    check("reload_s_ready", 64'(bus.s_ready), 64'd1);
    bus.feat_ready = 1'b1;
    wait_drain("drain_f2");
    check("drained_feat_valid", 64'(bus.feat_valid), 64'd0);

    for (int v = 0; v < 5; v++) begin
      err0 = err_seen;
      cnt0 = frame_cnt;
      if (vecs[v].exp_frames != 0) exp_q.push_back(build(vecs[v].base));
      send_frame(vecs[v].nwords, vecs[v].last_at, vecs[v].gaps, vecs[v].base);
      repeat (4) @(negedge clk);
      wait_drain($sformatf("%0s_drain", vecs[v].name));
      check($sformatf("%0s_err", vecs[v].name), 64'(err_seen - err0), 64'(vecs[v].exp_err));
      check($sformatf("%0s_cnt", vecs[v].name), 64'(frame_cnt - cnt0), 64'(vecs[v].exp_frames));
    end

    // Reset in the middle of a frame.
    send_frame(21, -1, 1'b0, 32'h4400_0000);
    rst_n = 1'b0;
    #1;
    check("midrst_feat_valid", 64'(bus.feat_valid), 64'd0);
    check("midrst_feature", 64'(bus.feature[1343:1280]), 64'd0);
    check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("midrst_s_ready", 64'(bus.s_ready), 64'd0);
    repeat (2) @(negedge clk);
    check("midrst_hold_feat_valid", 64'(bus.feat_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(build(32'h4200_0000));
    send_frame(NUM_FEAT, NUM_FEAT - 1, 1'b0, 32'h4200_0000);
    repeat (3) @(negedge clk);
    wait_drain("postrst_drain");
    check("postrst_frame_cnt", 64'(frame_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
